pwm_peripheral: RTL and testbench

Downstream consumer of the SPI register file: takes the five 8-bit control registers (output enables, PWM enables, duty cycle) and drives 16 output pins. Each pin is either forced low, forced high, or driven by one shared PWM waveform. A prescaled 8-bit counter generates the waveform at roughly 3 kHz from a 10 MHz `clk`.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_peripheral.sv | 87 ++++++++
 tb/tb_pwm_peripheral.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output block.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W        = 8;
    localparam logic [7:0]  PWM_DUTY_FULL    = 8'hFF;
    localparam int unsigned PWM_NUM_PINS     = 16;
    localparam int unsigned PRESCALE_DEFAULT = 13;

    typedef enum logic [1:0] {
        PIN_LOW,
        PIN_HIGH,
        PIN_PWM
    } pin_mode_e;

    // Output enable dominates: a disabled pin is low whatever its PWM select says.
    function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
        if (!en_out)
            return PIN_LOW;
        else if (!en_pwm)
            return PIN_HIGH;
        else
            return PIN_PWM;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock prescaler: tick is high for one clk in every PRESCALE.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned       PRE_W   = cnt_width(PRESCALE);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pre_cnt <= '0;
        else if (pre_cnt == PRE_MAX)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // PRESCALE=1 leaves pre_cnt pinned at 0, so tick is constantly high.
    assign tick = (pre_cnt == PRE_MAX);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output driver with one shared PWM waveform (256 x PRESCALE clk period).
// Define PWM_DUTY_SHADOW_EN to load the duty value only at period wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              en_reg_out_7_0,
    input  logic [7:0]              en_reg_out_15_8,
    input  logic [7:0]              en_reg_pwm_7_0,
    input  logic [7:0]              en_reg_pwm_15_8,
    input  logic [7:0]              pwm_duty_cycle,
    output logic [PWM_NUM_PINS-1:0] out,
    output logic                    period_start
);

    logic                    tick;
    logic                    wrap;
    logic [PWM_CNT_W-1:0]    pwm_cnt;
    logic [PWM_CNT_W-1:0]    duty_eff;
    logic                    pwm_lvl;
    logic [PWM_NUM_PINS-1:0] en_out;
    logic [PWM_NUM_PINS-1:0] en_pwm;
    logic [PWM_NUM_PINS-1:0] out_nxt;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pwm_cnt <= '0;
        else if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign wrap = tick && (pwm_cnt == '1);

`ifdef PWM_DUTY_SHADOW_EN
    logic [PWM_CNT_W-1:0] duty_shadow;

    // Loaded on the wrap edge, so the new value governs the period that starts there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            duty_shadow <= '0;
        else if (wrap)
            duty_shadow <= pwm_duty_cycle;
    end

    assign duty_eff = duty_shadow;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    assign pwm_lvl = (duty_eff == PWM_DUTY_FULL) || (pwm_cnt < duty_eff);

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        out_nxt = '0;
        for (int unsigned i = 0; i < PWM_NUM_PINS; i++) begin
            case (pin_mode(en_out[i], en_pwm[i]))
                PIN_LOW:  out_nxt[i] = 1'b0;
                PIN_HIGH: out_nxt[i] = 1'b1;
                default:  out_nxt[i] = pwm_lvl;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= out_nxt;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral at PRESCALE=4 (period 1024 clk).
module tb_pwm_peripheral;

    localparam int unsigned P      = 4;
    localparam int unsigned PERIOD = 256 * P;
`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out;
    logic        period_start;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_reg_out_7_0 (eo_lo),
        .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0 (ep_lo),
        .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle (duty),
        .out            (out),
        .period_start   (period_start)
    );

    always #50 clk = ~clk;

    typedef struct {
        int unsigned at;
        logic [16:0] exp;
        string       name;
    } snap_t;

    typedef struct {
        int unsigned high;
        int unsigned len;
        string       name;
    } per_t;

    snap_t       snap_q[$];
    per_t        per_q[$];
    int unsigned rel_q[$];

    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;
    int unsigned rel_edges  = 0;
    int unsigned win_len    = 0;
    int unsigned win_high   = 0;
    bit          first_ps   = 1'b1;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst) begin
        if (!rst) rel_edges = 0;
        else      rel_edges++;
    end

    // Monitor: snapshot checks by cycle, period checks on each period_start.
    always @(negedge clk) begin
        snap_t       s;
        per_t        p;
        int unsigned e;
        while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
            s = snap_q.pop_front();
            compared++;
            if (s.at != cyc || {period_start, out} !== s.exp) begin
                mismatched++;
                $display("FAIL %s: got ps=%0b out=0x%04h (cycle %0d), required ps=%0b out=0x%04h (cycle %0d)",
                         s.name, period_start, out, cyc, s.exp[16], s.exp[15:0], s.at);
            end
        end
        if (!rst) begin
            first_ps = 1'b1;
            win_len  = 0;
            win_high = 0;
        end else if (period_start) begin
            if (first_ps) begin
                if (rel_q.size() > 0) begin
                    e = rel_q.pop_front();
                    compared++;
                    if (rel_edges != e) begin
                        mismatched++;
                        $display("FAIL first_ps_after_rst: got %0d clocks after release, required %0d",
                                 rel_edges, e);
                    end
                end
                first_ps = 1'b0;
            end else if (per_q.size() > 0) begin
                p = per_q.pop_front();
                compared++;
                if (win_high != p.high || win_len != p.len) begin
                    mismatched++;
                    $display("FAIL %s: got high=%0d period=%0d, required high=%0d period=%0d",
                             p.name, win_high, win_len, p.high, p.len);
                end
            end
            win_len  = 1;
            win_high = out[0];
        end else begin
            win_len++;
            win_high += out[0];
        end
    end

    task automatic tick_n(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_snap(input string name, input int unsigned dly,
                               input logic [15:0] o, input logic ps);
        snap_t s;
        s.at   = cyc + dly;
        s.exp  = {ps, o};
        s.name = name;
        snap_q.push_back(s);
    endtask

    task automatic expect_per(input string name, input int unsigned high);
        per_t p;
        p.high = high;
        p.len  = PERIOD;
        p.name = name;
        per_q.push_back(p);
    endtask

    task automatic wait_ps(input string name);
        int unsigned n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!period_start && n < 3 * PERIOD);
        if (!period_start) begin
            compared++;
            mismatched++;
            $display("FAIL %s: got no period_start within %0d clocks, required one", name, n);
        end
    endtask

    task automatic run_duty(input string name, input logic [7:0] d,
                            input int unsigned high, input int unsigned nper);
        duty = d;
        wait_ps(name);
        tick_n(1);
        repeat (nper) expect_per(name, high);
        repeat (nper) wait_ps(name);
    endtask

    initial begin
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'hFF;

        tick_n(3);
        expect_snap("reset_hold", 0, 16'h0000, 1'b0);
        tick_n(1);
        rst = 1'b1;
        expect_snap("reset_release", 2, SH ? 16'h0000 : 16'hFFFF, 1'b0);
        tick_n(2);

        eo_lo = 8'h01; eo_hi = 8'h80; ep_lo = 8'h00; ep_hi = 8'h00;
        expect_snap("static_8001", 1, 16'h8001, 1'b0);
        tick_n(1);
        eo_lo = 8'h00;
        expect_snap("static_latency", 0, 16'h8001, 1'b0);
        expect_snap("static_8000", 1, 16'h8000, 1'b0);
        tick_n(1);
        eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'hFF; ep_hi = 8'hFF;
        expect_snap("disable_wins", 1, 16'h0000, 1'b0);
        tick_n(1);
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'h0F; ep_hi = 8'h0F;
        expect_snap("mix_duty_ff", 1, SH ? 16'hF0F0 : 16'hFFFF, 1'b0);
        tick_n(1);
        duty = 8'h00;
        expect_snap("mix_duty_00", 1, 16'hF0F0, 1'b0);
        tick_n(1);

        eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h01; ep_hi = 8'h00;
        run_duty("ratio_80", 8'h80, 512, 2);
        run_duty("duty_00", 8'h00, 0, 2);
        run_duty("duty_ff", 8'hFF, PERIOD, 2);
        run_duty("duty_01", 8'h01, P, 2);

        // Duty 0x40 -> 0xC0 while pwm_cnt reads 0x20.
        duty = 8'h40;
        wait_ps("shadow_sync");
        tick_n(1);
        expect_per("shadow_cur", SH ? 8'h40 * P : 8'hC0 * P);
        expect_per("shadow_next", 8'hC0 * P);
        tick_n(8'h20 * P - 1);
        duty = 8'hC0;
        wait_ps("shadow_cur");
        wait_ps("shadow_next");

        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'h00; ep_hi = 8'h00;
        wait_ps("midrst_sync");
        tick_n(8'h77 * P);
        rst = 1'b0;
        expect_snap("rst_async", 0, 16'h0000, 1'b0);
        tick_n(2);
        expect_snap("rst_held", 0, 16'h0000, 1'b0);
        rst = 1'b1;
        rel_q.push_back(PERIOD);
        expect_snap("rst_release", 1, 16'hFFFF, 1'b0);
        wait_ps("first_ps_after_rst");
        tick_n(2);

        if (snap_q.size() + per_q.size() + rel_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL unconsumed: got %0d pending expectations, required 0",
                     snap_q.size() + per_q.size() + rel_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
